// File: rtl/tick_scheduler_if.sv
// Configuration and status bundle for the tick scheduler.
// master drives config/control, slave is the scheduler.
interface tick_scheduler_if #(
   parameter int WIDTH     = 26,
   parameter int CNT_WIDTH = 8
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [WIDTH-1:0]     cfg_div;
   logic                 cfg_oneshot;
   logic [CNT_WIDTH-1:0] cfg_count;
   logic                 start;
   logic                 stop;
   logic                 busy;
   logic                 tick;
   logic                 new_clock;
   logic                 done;

   modport master (
      output cfg_valid, cfg_div, cfg_oneshot, cfg_count,
      output start, stop,
      input  cfg_ready, busy, tick, new_clock, done
   );

   modport slave (
      input  cfg_valid, cfg_div, cfg_oneshot, cfg_count,
      input  start, stop,
      output cfg_ready, busy, tick, new_clock, done
   );
endinterface

// File: rtl/tick_scheduler.sv
// Programmable timebase: tick enable, divided clock, one-shot and
// continuous runs, with divisor updates only at period boundaries.
module tick_scheduler #(
   parameter int WIDTH       = 26,
   parameter int DEFAULT_DIV = 50000000,
   parameter int CNT_WIDTH   = 8
) (
   input logic             clock,
   input logic             reset,
   tick_scheduler_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     count_q, count_d;
   logic [WIDTH-1:0]     div_q, div_d;
   logic [WIDTH-1:0]     pdiv_q, pdiv_d;
   logic                 os_q, os_d;
   logic                 pos_q, pos_d;
   logic                 run_os_q, run_os_d;
   logic                 pend_q, pend_d;
   logic                 stop_q, stop_d;
   logic                 nclk_q, nclk_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;

   logic                 xfer;
   logic                 at_end;
   logic                 fin;
   logic [WIDTH-1:0]     cdiv;
   logic [CNT_WIDTH-1:0] ccnt;

   assign cdiv   = (bus.cfg_div < WIDTH'(2)) ? WIDTH'(2) : bus.cfg_div;
   assign ccnt   = (bus.cfg_count == '0) ? CNT_WIDTH'(1) : bus.cfg_count;
   assign xfer   = bus.cfg_valid && !pend_q;
   assign at_end = (state_q == RUN) && (count_q == div_q - WIDTH'(1));
   assign fin    = at_end && (stop_q || bus.stop ||
                   (run_os_q && rem_q == CNT_WIDTH'(1)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         div_q    <= WIDTH'(DEFAULT_DIV);
         pdiv_q   <= '0;
         os_q     <= 1'b0;
         pos_q    <= 1'b0;
         run_os_q <= 1'b0;
         pend_q   <= 1'b0;
         stop_q   <= 1'b0;
         nclk_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= CNT_WIDTH'(1);
         pcnt_q   <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         div_q    <= div_d;
         pdiv_q   <= pdiv_d;
         os_q     <= os_d;
         pos_q    <= pos_d;
         run_os_q <= run_os_d;
         pend_q   <= pend_d;
         stop_q   <= stop_d;
         nclk_q   <= nclk_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         pcnt_q   <= pcnt_d;
         rem_q    <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start) state_d = RUN;
         RUN:  if (fin) state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      div_d    = div_q;
      pdiv_d   = pdiv_q;
      os_d     = os_q;
      pos_d    = pos_q;
      cnt_d    = cnt_q;
      pcnt_d   = pcnt_q;
      pend_d   = pend_q;
      run_os_d = run_os_q;
      rem_d    = rem_q;
      stop_d   = stop_q;
      unique case (state_q)
         IDLE: begin
            count_d = '0;
            if (xfer) begin
               div_d = cdiv;
               os_d  = bus.cfg_oneshot;
               cnt_d = ccnt;
            end
            // a config offered with start governs this run
            if (bus.start) begin
               run_os_d = xfer ? bus.cfg_oneshot : os_q;
               rem_d    = xfer ? ccnt : cnt_q;
               stop_d   = 1'b0;
            end
         end
         RUN: begin
            count_d = at_end ? '0 : count_q + WIDTH'(1);
            if (bus.stop) stop_d = 1'b1;
            if (at_end) begin
               if (pend_q) begin
                  div_d  = pdiv_q;
                  os_d   = pos_q;
                  cnt_d  = pcnt_q;
                  pend_d = 1'b0;
               end else if (xfer) begin
                  div_d = cdiv;
                  os_d  = bus.cfg_oneshot;
                  cnt_d = ccnt;
               end
               if (fin) stop_d = 1'b0;
               else if (run_os_q) rem_d = rem_q - CNT_WIDTH'(1);
            end else if (xfer) begin
               pdiv_d = cdiv;
               pos_d  = bus.cfg_oneshot;
               pcnt_d = ccnt;
               pend_d = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      nclk_d = (state_d == RUN) &&
               (count_d > ((div_d - WIDTH'(1)) >> 1));
      done_d = fin;
      bus.busy      = (state_q == RUN);
      bus.tick      = at_end;
      bus.new_clock = nclk_q;
      bus.done      = done_q;
      bus.cfg_ready = !pend_q;
   end
endmodule
